serial_pattern_generator: RTL and testbench
===========================================

Name: serial_pattern_generator

Overview:
- Serial bit-stream transmitter. It is the driving end of the team's serial sequence detectors.
- Loads an up-to-8-bit pattern and shifts it out MSB-first on a single data line, at a programmable bit period.
- Repeats the pattern a programmable number of times, with an idle gap between frames.
- Handshake is start/busy/done, with a synchronous abort. Used as an on-chip stimulus source for detector FSMs and as a standalone pattern output.

Parameters:
- PAT_W, 8, maximum pattern length in bits.
- DIV_W, 8, width of the bit-period divider field.
- GAP_BITS, 1, idle bit-periods inserted between repeated frames (0 = back-to-back).
- IDLE_LEVEL, 1, level driven on ser_out when not transmitting a frame bit.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a job; sampled only in IDLE.
- abort  input  1  synchronous cancel of the current job.
- pattern  input  PAT_W  bits to send; active bits are pattern[len-1:0].
- len  input  4  frame length in bits; 0 = invalid; values above PAT_W clamp to PAT_W.
- repeat_cnt  input  4  additional frames; total frames = repeat_cnt+1.
- bit_div  input  DIV_W  each bit is held bit_div+1 clock cycles.
- ser_out  output  1  serial data line.
- ser_valid  output  1  high while ser_out carries a frame bit.
- busy  output  1  job in progress.
- done  output  1  one-cycle pulse on normal job completion.
- frame_cnt  output  5  frames fully sent in the current or last job.

Behaviour:
- Reset (sampled high at a rising edge) produces these values from the next cycle:
  - state=IDLE, ser_out=IDLE_LEVEL, ser_valid=0, busy=0, done=0, frame_cnt=0.
  - All internal latches and counters are cleared.
- Reset has priority over abort and start, including mid-job.
- State machine states: IDLE, SHIFT, GAP.
- IDLE:
  - start=1 with len!=0 at edge t: latch pattern, clamped len, repeat_cnt and bit_div. Clear frame_cnt. Go to SHIFT.
  - From cycle t+1: busy=1, ser_valid=1, ser_out=pattern[len-1].
  - start with len=0 is ignored: no state change, no done.
- SHIFT:
  - A divider counter counts bit_div+1 cycles per bit; bit index steps len-1 down to 0.
  - ser_out changes only at bit boundaries.
  - After the last cycle of bit 0, frame_cnt increments. Then:
    - more frames remaining and GAP_BITS>0: go to GAP;
    - more frames remaining and GAP_BITS=0: restart at bit len-1 immediately, no idle cycle;
    - otherwise: go to IDLE.
- GAP:
  - ser_out=IDLE_LEVEL, ser_valid=0, busy=1.
  - Lasts GAP_BITS*(bit_div+1) cycles, then SHIFT at bit len-1.
- Completion:
  - On the edge leaving SHIFT for IDLE: busy=0, ser_valid=0, ser_out=IDLE_LEVEL, done=1 for exactly one cycle.
  - frame_cnt holds its final value until the next accepted start.
- Latency: first bit is visible 1 cycle after start is sampled. Busy duration in cycles = (repeat_cnt+1)*len*(bit_div+1) + repeat_cnt*GAP_BITS*(bit_div+1).
- Pattern, len, repeat_cnt and bit_div may change during a job with no effect, because values are latched at start.
- start while busy is ignored. start in the same cycle that done is asserted is accepted (state is IDLE then).
- abort=1 in SHIFT or GAP: return to IDLE at the next edge with the IDLE output values, no done pulse. frame_cnt keeps the frames completed so far. abort in IDLE has no effect.
- abort and start in the same IDLE cycle: start wins.
- frame_cnt maximum is 16 (repeat_cnt=15); no wrap.

Test Plan:
- Basic frame: pattern=8'h06, len=4, repeat_cnt=0, bit_div=0 -> ser_out 0,1,1,0 in cycles t+1..t+4, ser_valid=1 over those 4 cycles; done pulse in cycle t+5; frame_cnt=1.
- Divider: same job with bit_div=2 -> each bit held 3 cycles; busy for 12 cycles; done in cycle t+13.
- Repeats with gap: pattern=3'b011, len=3, repeat_cnt=2, bit_div=0, GAP_BITS=1 -> ser_out 0,1,1,I,0,1,1,I,0,1,1 (I=IDLE_LEVEL, ser_valid=0 on gap cycles); busy 11 cycles; frame_cnt=3.
- Handshake guards: start pulsed mid-job -> stream unchanged; start with len=0 -> busy stays 0, no done; len=12 -> 8-bit frame sent.
- Abort and reset: abort at the 3rd bit of frame 2 -> next cycle busy=0, ser_out=IDLE_LEVEL, no done, frame_cnt=1. Reset mid-frame -> all outputs at reset values next cycle.
- Back-to-back: GAP_BITS=0, pattern=2'b10, len=2, repeat_cnt=1 -> ser_out 1,0,1,0 contiguous; frame_cnt=2; start in the done cycle launches a new job.

Source files
------------

// File: rtl/serial_pattern_generator.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first at a programmable
// bit period, repeating it with an optional idle gap between frames.
module serial_pattern_generator #(
  parameter int unsigned PAT_W      = 8,
  parameter int unsigned DIV_W      = 8,
  parameter int unsigned GAP_BITS   = 1,
  parameter bit          IDLE_LEVEL = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [3:0]       len_i,
  input  logic [3:0]       repeat_cnt_i,
  input  logic [DIV_W-1:0] bit_div_i,
  output logic             ser_out_o,
  output logic             ser_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [4:0]       frame_cnt_o
);

  localparam int unsigned IdxW = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e            state_q;
  logic [PAT_W-1:0]  pat_q;
  logic [3:0]        len_q;
  logic [3:0]        rep_left_q;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_cnt_q;
  logic [IdxW-1:0]   bit_idx_q;
  logic [7:0]        gap_cnt_q;
  logic [4:0]        frame_cnt_q;
  logic              ser_out_q;
  logic              ser_valid_q;
  logic              busy_q;
  logic              done_q;

  logic [3:0]        len_clamp;
  logic [IdxW-1:0]   start_idx;
  logic [IdxW-1:0]   last_idx;
  logic [IdxW-1:0]   next_idx;
  logic              div_end;
  logic              gap_end;

  always_comb begin
    len_clamp = (32'(len_i) > PAT_W) ? 4'(PAT_W) : len_i;
    start_idx = IdxW'(len_clamp - 4'd1);
    last_idx  = IdxW'(len_q - 4'd1);
    next_idx  = bit_idx_q - IdxW'(1);
    div_end   = (div_cnt_q == div_q);
    // Never true when GAP_BITS is 0; the gap state is then unreachable.
    gap_end   = (32'(gap_cnt_q) == GAP_BITS - 1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      pat_q       <= '0;
      len_q       <= '0;
      rep_left_q  <= '0;
      div_q       <= '0;
      div_cnt_q   <= '0;
      bit_idx_q   <= '0;
      gap_cnt_q   <= '0;
      frame_cnt_q <= '0;
      ser_out_q   <= IDLE_LEVEL;
      ser_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i && (len_i != 4'd0)) begin
            state_q     <= StShift;
            pat_q       <= pattern_i;
            len_q       <= len_clamp;
            rep_left_q  <= repeat_cnt_i;
            div_q       <= bit_div_i;
            div_cnt_q   <= '0;
            bit_idx_q   <= start_idx;
            frame_cnt_q <= '0;
            ser_out_q   <= pattern_i[start_idx];
            ser_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        StShift: begin
          if (abort_i) begin
            state_q     <= StIdle;
            ser_out_q   <= IDLE_LEVEL;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end else if (!div_end) begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end else begin
            div_cnt_q <= '0;
            if (bit_idx_q != '0) begin
              bit_idx_q <= next_idx;
              ser_out_q <= pat_q[next_idx];
            end else begin
              frame_cnt_q <= frame_cnt_q + 5'd1;
              if (rep_left_q != 4'd0) begin
                rep_left_q <= rep_left_q - 4'd1;
                if (GAP_BITS > 0) begin
                  state_q     <= StGap;
                  gap_cnt_q   <= '0;
                  ser_out_q   <= IDLE_LEVEL;
                  ser_valid_q <= 1'b0;
                end else begin
                  bit_idx_q <= last_idx;
                  ser_out_q <= pat_q[last_idx];
                end
              end else begin
                state_q     <= StIdle;
                ser_out_q   <= IDLE_LEVEL;
                ser_valid_q <= 1'b0;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
              end
            end
          end
        end
        StGap: begin
          if (abort_i) begin
            state_q     <= StIdle;
            ser_out_q   <= IDLE_LEVEL;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end else if (!div_end) begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end else begin
            div_cnt_q <= '0;
            if (gap_end) begin
              state_q     <= StShift;
              bit_idx_q   <= last_idx;
              ser_out_q   <= pat_q[last_idx];
              ser_valid_q <= 1'b1;
            end else begin
              gap_cnt_q <= gap_cnt_q + 8'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ser_out_o   = ser_out_q;
  assign ser_valid_o = ser_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_serial_pattern_generator.sv
// Directed bench for serial_pattern_generator: one instance with a one-period gap,
// one with back-to-back frames, checked against hand-computed streams.
module tb_serial_pattern_generator;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] repeat_cnt;
  logic [7:0] bit_div;

  logic       a_out, a_valid, a_busy, a_done;
  logic [4:0] a_fcnt;
  logic       b_out, b_valid, b_busy, b_done;
  logic [4:0] b_fcnt;

  int errors = 0;
  int checks = 0;

  serial_pattern_generator #(
    .PAT_W(8), .DIV_W(8), .GAP_BITS(1), .IDLE_LEVEL(1'b1)
  ) u_dut_gap (
    .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
    .pattern_i(pattern), .len_i(len), .repeat_cnt_i(repeat_cnt), .bit_div_i(bit_div),
    .ser_out_o(a_out), .ser_valid_o(a_valid), .busy_o(a_busy), .done_o(a_done),
    .frame_cnt_o(a_fcnt)
  );

  serial_pattern_generator #(
    .PAT_W(8), .DIV_W(8), .GAP_BITS(0), .IDLE_LEVEL(1'b1)
  ) u_dut_b2b (
    .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
    .pattern_i(pattern), .len_i(len), .repeat_cnt_i(repeat_cnt), .bit_div_i(bit_div),
    .ser_out_o(b_out), .ser_valid_o(b_valid), .busy_o(b_busy), .done_o(b_done),
    .frame_cnt_o(b_fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {busy, valid, ser_out, done} of the selected instance.
  function automatic logic [3:0] outs(input bit sel);
    return sel ? {b_busy, b_valid, b_out, b_done} : {a_busy, a_valid, a_out, a_done};
  endfunction

  // Checks n stream cycles starting in the current cycle (MSB-first vectors), then the done
  // cycle. If poke >= 0, a conflicting start is pulsed during stream cycle poke.
  task automatic run_stream(input string tag, input bit sel, input logic [31:0] exp_out,
                            input logic [31:0] exp_val, input int n, input int poke);
    logic [7:0]  save_pat;
    logic [3:0]  save_len;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_c%0d", tag, i), 32'(outs(sel)),
            32'({1'b1, exp_val[n-1-i], exp_out[n-1-i], 1'b0}));
      if (i == poke) begin
        save_pat = pattern;
        save_len = len;
        start    = 1'b1;
        pattern  = 8'hff;
        len      = 4'd8;
        tick();
        start    = 1'b0;
        pattern  = save_pat;
        len      = save_len;
      end else begin
        tick();
      end
    end
    check($sformatf("%s_done", tag), 32'(outs(sel)), 32'(4'b0011));
  endtask

  task automatic launch(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                        input logic [7:0] d);
    pattern    = p;
    len        = l;
    repeat_cnt = r;
    bit_div    = d;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    pattern = '0; len = '0; repeat_cnt = '0; bit_div = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_outs", 32'(outs(1'b0)), 32'(4'b0010));
    check("reset_fcnt", 32'(a_fcnt), 32'd0);

    // Basic frame
    launch(8'h06, 4'd4, 4'd0, 8'd0);
    run_stream("basic", 1'b0, 32'b0110, 32'b1111, 4, -1);
    check("basic_fcnt", 32'(a_fcnt), 32'd1);
    tick();
    check("basic_done_once", 32'(a_done), 32'd0);

    // Divider: bit_div=2, plus pattern changes mid-job must not matter
    launch(8'h06, 4'd4, 4'd0, 8'd2);
    pattern = 8'hf9; len = 4'd7; bit_div = 8'd0;
    run_stream("div", 1'b0, 32'b000111111000, 32'hfff, 12, -1);
    tick();

    // Repeats with gap and a mid-job start pulse
    launch(8'b011, 4'd3, 4'd2, 8'd0);
    run_stream("gap", 1'b0, 32'b01110111011, 32'b11101110111, 11, 5);
    check("gap_fcnt", 32'(a_fcnt), 32'd3);
    tick();

    // len=0 is ignored
    launch(8'hff, 4'd0, 4'd0, 8'd0);
    check("len0_busy", 32'(outs(1'b0)), 32'(4'b0010));
    tick();
    check("len0_nodone", 32'(outs(1'b0)), 32'(4'b0010));
    check("len0_fcnt_held", 32'(a_fcnt), 32'd3);

    // len=12 clamps to 8
    launch(8'ha5, 4'd12, 4'd0, 8'd0);
    run_stream("clamp", 1'b0, 32'b10100101, 32'hff, 8, -1);
    check("clamp_fcnt", 32'(a_fcnt), 32'd1);
    tick();

    // Abort on third bit of frame 2 (pattern bits 1,0,0,1; gap in cycle 5)
    launch(8'b1001, 4'd4, 4'd2, 8'd0);
    for (int i = 0; i < 7; i++) tick();
    check("abort_bit3", 32'(outs(1'b0)), 32'(4'b1100));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_outs", 32'(outs(1'b0)), 32'(4'b0010));
    check("abort_fcnt", 32'(a_fcnt), 32'd1);
    tick();
    check("abort_nodone", 32'(outs(1'b0)), 32'(4'b0010));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle_noeffect", 32'(a_fcnt), 32'd1);

    // Reset during frame 2 bit 1
    launch(8'h00, 4'd2, 4'd1, 8'd0);
    tick(); tick(); tick();
    check("rst_pre", 32'({outs(1'b0), a_fcnt}), 32'({4'b1100, 5'd1}));
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("rst_mid_outs", 32'(outs(1'b0)), 32'(4'b0010));
    check("rst_mid_fcnt", 32'(a_fcnt), 32'd0);
    check("rst_mid_b2b", 32'(outs(1'b1)), 32'(4'b0010));

    // Back-to-back, then start in the done cycle
    launch(8'b10, 4'd2, 4'd1, 8'd0);
    run_stream("b2b", 1'b1, 32'b1010, 32'b1111, 4, -1);
    check("b2b_fcnt", 32'(b_fcnt), 32'd2);
    launch(8'b01, 4'd2, 4'd0, 8'd0);
    run_stream("b2b_rearm", 1'b1, 32'b01, 32'b11, 2, -1);
    check("b2b_rearm_fcnt", 32'(b_fcnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
